// File: rtl/sevenseg_scan_drv.sv
// rtl/sevenseg_scan_drv.sv - time-multiplexed N-digit 7-segment scan driver
// Optional leading-zero blanking is built when SEVENSEG_LZB_EN is defined.
module sevenseg_scan_drv #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 1000,
  parameter int BLANK_CYCLES   = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dots,
  output logic [7:0]              sevenseg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]         SHOW_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    snap;
  logic [4*NUM_DIGITS-1:0] digits_sh;
  logic [NUM_DIGITS-1:0]   dots_sh;
  logic [3:0]              nib;
  logic                    dp;
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic                    fs_n;

`ifdef SEVENSEG_LZB_EN
  logic [NUM_DIGITS-1:0]   lzb_mask, lzb_mask_n;
  logic                    lzb_seen;
  logic                    blank_ag;
`endif

  function automatic logic [7:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 8'hFC;
      4'h1: hex7 = 8'h60;
      4'h2: hex7 = 8'hDA;
      4'h3: hex7 = 8'hF2;
      4'h4: hex7 = 8'h66;
      4'h5: hex7 = 8'hB6;
      4'h6: hex7 = 8'hBE;
      4'h7: hex7 = 8'hE0;
      4'h8: hex7 = 8'hFE;
      4'h9: hex7 = 8'hF6;
      4'hA: hex7 = 8'hEE;
      4'hB: hex7 = 8'h3E;
      4'hC: hex7 = 8'h9C;
      4'hD: hex7 = 8'h7A;
      4'hE: hex7 = 8'h9E;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  // Scan sequencer: everything freezes while en is low.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    snap    = 1'b0;
    if (en) begin
      case (state)
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_n = '0;
            if (BLANK_CYCLES == 0) begin
              if (idx == IDX_LAST) begin
                idx_n = '0;
                snap  = 1'b1;
              end else begin
                idx_n = idx + 1'b1;
              end
            end else begin
              state_n = ST_BLANK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          if ((BLANK_CYCLES == 0) || (cnt == BLANK_LAST)) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n = '0;
              snap  = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SEVENSEG_LZB_EN
  // Mask is built from the values being snapshotted so it lines up with the shadow copy.
  always_comb begin
    lzb_seen   = 1'b0;
    lzb_mask_n = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (digits[4*i +: 4] != 4'h0) lzb_seen = 1'b1;
      lzb_mask_n[i] = !lzb_seen;
    end
  end
`endif

  always_comb begin
    nib   = 4'h0;
    dp    = 1'b0;
    sel_n = '0;
`ifdef SEVENSEG_LZB_EN
    blank_ag = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib      = digits_sh[4*i +: 4];
        dp       = dots_sh[i];
        sel_n[i] = 1'b1;
`ifdef SEVENSEG_LZB_EN
        blank_ag = lzb_mask[i];
`endif
      end
    end
  end

  // Outputs are registered from the current state, so they trail the sequencer by one clock.
  always_comb begin
    seg_n = 8'h00;
    fs_n  = 1'b0;
    if (en && (state == ST_SHOW)) begin
      seg_n = hex7(nib) | {7'b0, dp};
`ifdef SEVENSEG_LZB_EN
      if (blank_ag) seg_n[7:1] = 7'b0;
`endif
      fs_n = (idx == '0) && (cnt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BLANK;
      idx         <= IDX_LAST;
      cnt         <= '0;
      digits_sh   <= '0;
      dots_sh     <= '0;
`ifdef SEVENSEG_LZB_EN
      lzb_mask    <= '0;
`endif
      sevenseg    <= SEG_OFF;
      digit_sel   <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      if (snap) begin
        digits_sh <= digits;
        dots_sh   <= dots;
`ifdef SEVENSEG_LZB_EN
        lzb_mask  <= lzb_mask_n;
`endif
      end
      sevenseg    <= seg_n ^ SEG_OFF;
      digit_sel   <= (en && (state == ST_SHOW)) ? (sel_n ^ DIG_OFF) : DIG_OFF;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_drv.sv
// tb/tb_sevenseg_scan_drv.sv - directed self-checking bench for sevenseg_scan_drv
module tb_sevenseg_scan_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic [15:0] digits_inv;
  logic [3:0]  dots_inv;
  logic [7:0]  sevenseg, sevenseg_inv;
  logic [3:0]  digit_sel, digit_sel_inv;
  logic        frame_start, frame_start_inv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sevenseg_scan_drv #(
    .NUM_DIGITS(4), .TICK_DIV(4), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dots(dots),
    .sevenseg(sevenseg), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  sevenseg_scan_drv #(
    .NUM_DIGITS(4), .TICK_DIV(4), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_inv (
    .clk(clk), .rst(rst), .en(en), .digits(digits_inv), .dots(dots_inv),
    .sevenseg(sevenseg_inv), .digit_sel(digit_sel_inv), .frame_start(frame_start_inv)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lit pattern per frame and digit, hand-decoded from the input values in force.
  function automatic logic [7:0] exp_seg(input int f, input int d);
    logic [7:0] z;
`ifdef SEVENSEG_LZB_EN
    z = 8'h00;
`else
    z = 8'hFC;
`endif
    if (f <= 1) begin
      case (d)
        0: exp_seg = 8'h8E;
        1: exp_seg = 8'hEE;
        2: exp_seg = 8'hDA;
        default: exp_seg = 8'h60;
      endcase
    end else if (f == 2) begin
      exp_seg = (d == 0) ? 8'hFC : z;
    end else if (f <= 4) begin
      exp_seg = (d % 2 == 0) ? 8'hFF : 8'hFE;
    end else begin
      case (d)
        0: exp_seg = 8'hFC;
        1: exp_seg = 8'hB6;
        default: exp_seg = z;
      endcase
    end
  endfunction

  initial begin
    int ke, f, m, d, r;
    logic       lit;
    logic [7:0] e_seg;
    logic [3:0] e_sel;
    logic       e_fs;

    rst        = 1'b1;
    en         = 1'b1;
    digits     = 16'h12AF;
    dots       = 4'b0000;
    digits_inv = 16'h0000;
    dots_inv   = 4'b0000;

    repeat (2) @(negedge clk);
    check_eq("reset seg", sevenseg, 8'h00);
    check_eq("reset sel", digit_sel, 4'b0000);
    check_eq("reset fs", frame_start, 1'b0);
    check_eq("reset inv seg", sevenseg_inv, 8'hFF);
    check_eq("reset inv sel", digit_sel_inv, 4'b1111);
    rst = 1'b0;

    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      lit = 1'b0;
      f = 0; m = 0; d = 0; r = 0;
      if (k <= 106) ke = k;
      else if (k <= 116) ke = 0;
      else ke = k - 10;
      if (ke >= 3) begin
        f = (ke - 3) / 24;
        m = (ke - 3) % 24;
        d = m / 6;
        r = m % 6;
        lit = (r < 4);
      end
      e_seg = lit ? exp_seg(f, d) : 8'h00;
      e_sel = lit ? 4'(1 << d) : 4'b0000;
      e_fs  = lit && (m == 0);
      check_eq($sformatf("seg k=%0d", k), sevenseg, e_seg);
      check_eq($sformatf("sel k=%0d", k), digit_sel, e_sel);
      check_eq($sformatf("fs k=%0d", k), frame_start, e_fs);

      if (k == 1) begin
        check_eq("inv blank seg", sevenseg_inv, 8'hFF);
        check_eq("inv blank sel", digit_sel_inv, 4'b1111);
      end
      if (k == 3) begin
        check_eq("inv digit0 seg", sevenseg_inv, 8'h03);
        check_eq("inv digit0 sel", digit_sel_inv, 4'b1110);
      end

      if (k == 40) digits = 16'h0000;
      if (k == 60) begin
        digits = 16'h8888;
        dots   = 4'b0101;
      end
      if (k == 106) en = 1'b0;
      if (k == 116) en = 1'b1;
      if (k == 120) begin
        digits = 16'h0050;
        dots   = 4'b0000;
      end
    end

    rst = 1'b1;
    #1;
    check_eq("async rst seg", sevenseg, 8'h00);
    check_eq("async rst sel", digit_sel, 4'b0000);
    check_eq("async rst fs", frame_start, 1'b0);
    check_eq("async rst inv seg", sevenseg_inv, 8'hFF);
    check_eq("async rst inv sel", digit_sel_inv, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
